poly_sweep_ctrl: RTL

Sweep controller placed directly upstream of the quadratic evaluator F(x,y,z). It walks every (x,y,z) operand triple in a programmable box and drives the evaluator's in0/in1/in2/en inputs. It waits for the evaluator's done pulse, then captures its 19-bit result. It keeps the running maximum and minimum of F with their coordinates, so a full search runs in hardware without host polling.

---
 rtl/poly_sweep_ctrl_if.sv | 13 +
 rtl/poly_sweep_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/poly_sweep_ctrl_if.sv
// Operand/handshake bundle between the sweep controller and the F(x,y,z) evaluator.
// The controller drives the operands and en; the evaluator answers with done_in/res_in.
interface poly_sweep_ctrl_if;
  logic [3:0]  in0;
  logic [3:0]  in1;
  logic [3:0]  in2;
  logic        en;
  logic        done_in;
  logic [18:0] res_in;

  modport master (output in0, in1, in2, en, input done_in, res_in);
  modport slave  (input in0, in1, in2, en, output done_in, res_in);
endinterface

// File: rtl/poly_sweep_ctrl.sv
// Walks every (x,y,z) in a programmable box through the quadratic evaluator and
// tracks the signed running maximum/minimum of F together with their coordinates.
module poly_sweep_ctrl #(
  parameter int X_MAX   = 15,
  parameter int Y_MAX   = 15,
  parameter int Z_MAX   = 15,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  poly_sweep_ctrl_if.master   ev,
  output logic                busy,
  output logic                sweep_done,
  output logic signed [18:0]  max_val,
  output logic [3:0]          max_x,
  output logic [3:0]          max_y,
  output logic [3:0]          max_z,
  output logic signed [18:0]  min_val,
  output logic [3:0]          min_x,
  output logic [3:0]          min_y,
  output logic [3:0]          min_z,
  output logic [12:0]         point_cnt,
  output logic                timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, ADVANCE, FINISH} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         x;
  logic [3:0]         y;
  logic [3:0]         z;
  logic [WW-1:0]      wait_cnt;
  logic               done_q;
  logic               first;
  logic signed [18:0] res_q;
  logic               done_rise;
  logic               wait_expired;
  logic               last_point;

  // Only a fresh 0->1 edge counts, so a done level left high from the previous point is ignored.
  assign done_rise    = ev.done_in && !done_q;
  assign wait_expired = (wait_cnt == WW'(TIMEOUT - 1));
  assign last_point   = (x == 4'(X_MAX)) && (y == 4'(Y_MAX)) && (z == 4'(Z_MAX));

  assign ev.in0 = x;
  assign ev.in1 = y;
  assign ev.in2 = z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ev.en      = 1'b0;
    busy       = 1'b1;
    sweep_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        ev.en     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_rise)         state_nxt = CAPTURE;
        else if (wait_expired) state_nxt = IDLE;
      end
      CAPTURE: state_nxt = ADVANCE;
      ADVANCE: state_nxt = last_point ? FINISH : ISSUE;
      FINISH: begin
        sweep_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      z           <= '0;
      wait_cnt    <= '0;
      done_q      <= 1'b0;
      first       <= 1'b0;
      res_q       <= '0;
      max_val     <= '0;
      max_x       <= '0;
      max_y       <= '0;
      max_z       <= '0;
      min_val     <= '0;
      min_x       <= '0;
      min_y       <= '0;
      min_z       <= '0;
      point_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      done_q <= ev.done_in;
      case (state)
        IDLE: begin
          if (start) begin
            point_cnt   <= '0;
            timeout_err <= 1'b0;
            x           <= '0;
            y           <= '0;
            z           <= '0;
            first       <= 1'b1;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (done_rise)         res_q       <= ev.res_in;
          else if (wait_expired) timeout_err <= 1'b1;
          else                   wait_cnt    <= wait_cnt + WW'(1);
        end
        CAPTURE: begin
          point_cnt <= point_cnt + 13'd1;
          first     <= 1'b0;
          // Strict compares keep the earliest point on ties; first forces a reload.
          if (first || res_q > max_val) begin
            max_val <= res_q;
            max_x   <= x;
            max_y   <= y;
            max_z   <= z;
          end
          if (first || res_q < min_val) begin
            min_val <= res_q;
            min_x   <= x;
            min_y   <= y;
            min_z   <= z;
          end
        end
        ADVANCE: begin
          if (z != 4'(Z_MAX)) begin
            z <= z + 4'd1;
          end else begin
            z <= '0;
            if (y != 4'(Y_MAX)) begin
              y <= y + 4'd1;
            end else begin
              y <= '0;
              if (x != 4'(X_MAX)) x <= x + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
